uart_tx_framer: RTL

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer_if.sv | 21 ++
 rtl/uart_tx_framer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/uart_tx_framer_if.sv
// Host-side transmit handshake and serial line status for uart_tx_framer.
interface uart_tx_framer_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;
   logic                 tx_out;
   logic                 tx_busy;
   logic                 tx_done;

   modport master (
      output tx_valid, tx_data,
      input  tx_ready, tx_out, tx_busy, tx_done
   );

   modport slave (
      input  tx_valid, tx_data,
      output tx_ready, tx_out, tx_busy, tx_done
   );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1-2 stop bits.
// All outputs are registered and computed from next-state values so they align with the state.
module uart_tx_framer #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY_EN  = 1,
   parameter int unsigned ODD_PARITY = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned BAUD_DIV   = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   uart_tx_framer_if.slave   tx_if
);
   localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_out_q, tx_out_d;
   logic                 tx_ready_q, tx_ready_d;
   logic                 tx_busy_q, tx_busy_d;
   logic                 tx_done_q, tx_done_d;
   logic                 baud_end;

   assign tx_if.tx_out   = tx_out_q;
   assign tx_if.tx_ready = tx_ready_q;
   assign tx_if.tx_busy  = tx_busy_q;
   assign tx_if.tx_done  = tx_done_q;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         tx_out_q   <= 1'b1;
         tx_ready_q <= 1'b1;
         tx_busy_q  <= 1'b0;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         tx_out_q   <= tx_out_d;
         tx_ready_q <= tx_ready_d;
         tx_busy_q  <= tx_busy_d;
         tx_done_q  <= tx_done_d;
      end
   end

   // Next-state, counters and next-cycle outputs
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      baud_end = (cnt_q == CNT_W'(BAUD_DIV - 1));

      if (state_q != IDLE) begin
         cnt_d = baud_end ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (tx_if.tx_valid) begin
               shift_d = tx_if.tx_data;
               par_d   = (^tx_if.tx_data) ^ 1'(ODD_PARITY);
               cnt_d   = '0;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (baud_end) begin
               bit_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (baud_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         PARITY: begin
            if (baud_end) begin
               bit_d   = '0;
               state_d = STOP;
            end
         end
         STOP: begin
            if (baud_end) begin
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = IDLE;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_out_d = 1'b0;
         DATA:    tx_out_d = shift_d[0];
         PARITY:  tx_out_d = par_q;
         default: tx_out_d = 1'b1;
      endcase

      tx_ready_d = (state_d == IDLE);
      tx_busy_d  = (state_d != IDLE);
      // Done marks the last cycle of the last stop bit
      tx_done_d  = (state_d == STOP) && (cnt_d == CNT_W'(BAUD_DIV - 1))
                   && (bit_d == BIT_W'(STOP_BITS - 1));
   end
endmodule
